// File: rtl/data_mem_resp_pkg.sv
// Shared encodings for the byte-serial data memory responder.
// Holds access-size and FSM state encodings plus alignment helpers.
package data_mem_resp_pkg;

    localparam int MEM_BYTES = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Index of the final byte of a field; the byte counter stops here.
    function automatic logic [1:0] last_idx(input size_e sz);
        case (sz)
            SZ_BYTE: last_idx = 2'd0;
            SZ_HALF: last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic req_error(input size_e sz, input logic [ADDR_W-1:0] addr);
        case (sz)
            SZ_BYTE: req_error = 1'b0;
            SZ_HALF: req_error = addr[0];
            SZ_WORD: req_error = (addr[1:0] != 2'b00);
            default: req_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_byte_ram.sv
// 256x8 single-port storage: synchronous write, asynchronous read.
// Deliberately has no reset so contents survive a controller reset.
module dmem_byte_ram
    import data_mem_resp_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_resp.sv
// Big-endian data memory moving one byte per cycle; IDLE/XFER/RESP handshake
// with BUSY stall, one-cycle DONE/ERR pulse and sign/zero-extended load data.
module data_mem_resp
    import data_mem_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        E,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic        SE,
    input  logic [7:0]  A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    state_e      r_state;
    state_e      w_next;
    logic [1:0]  r_cnt;
    logic        r_rw;
    logic        r_se;
    logic        r_err;
    size_e       r_size;
    logic [7:0]  r_addr;
    logic [31:0] r_shift;

    logic        w_accept;
    logic        w_req_err;
    logic        w_last;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_rdata;
    logic [31:0] w_field;

    function automatic logic [31:0] extend(input logic [31:0] f, input size_e sz, input logic se);
        case (sz)
            SZ_BYTE: extend = se ? {{24{f[7]}}, f[7:0]} : {24'd0, f[7:0]};
            SZ_HALF: extend = se ? {{16{f[15]}}, f[15:0]} : {16'd0, f[15:0]};
            default: extend = f;
        endcase
    endfunction

    // Store data is left-justified so the top byte is always the next one out.
    function automatic logic [31:0] align(input logic [31:0] d, input size_e sz);
        case (sz)
            SZ_BYTE: align = {d[7:0], 24'd0};
            SZ_HALF: align = {d[15:0], 16'd0};
            default: align = d;
        endcase
    endfunction

    assign w_accept  = (r_state == ST_IDLE) && E;
    assign w_req_err = req_error(size_e'(SIZE), A);
    assign w_last    = (r_cnt == last_idx(r_size));
    assign w_addr    = r_addr + {6'd0, r_cnt};
    assign w_we      = (r_state == ST_XFER) && r_rw;
    assign w_field   = {r_shift[23:0], w_rdata};

    dmem_byte_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (r_shift[31:24]),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (E) w_next = w_req_err ? ST_RESP : ST_XFER;
            ST_XFER: if (w_last) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            DO      <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_XFER && !w_last) begin
                r_cnt <= r_cnt + 2'd1;
            end else begin
                r_cnt <= 2'd0;
            end
            if (w_accept && w_req_err) begin
                DO <= 32'd0;
            end else if (r_state == ST_XFER && w_last && !r_rw) begin
                DO <= extend(w_field, r_size, r_se);
            end
        end
    end

    // Request fields and the shift register carry data only, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rw    <= RW;
            r_size  <= size_e'(SIZE);
            r_se    <= SE;
            r_addr  <= A;
            r_err   <= w_req_err;
            r_shift <= align(DI, size_e'(SIZE));
        end else if (r_state == ST_XFER) begin
            r_shift <= w_field;
        end
    end

    assign BUSY = (r_state != ST_IDLE);
    assign DONE = (r_state == ST_RESP);
    assign ERR  = DONE && r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: expectations come from a byte-array
// model, are queued at issue time and compared when DONE appears.
module tb_data_mem_resp;

    logic        clk;
    logic        reset;
    logic        E;
    logic        RW;
    logic [1:0]  SIZE;
    logic        SE;
    logic [7:0]  A;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
        int          busy;
    } exp_t;

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic        se;
        logic [7:0]  a;
        logic [31:0] di;
    } stim_t;

    exp_t        sb[$];
    logic [7:0]  m [256];
    logic [31:0] last_do;
    int          passed;
    int          total;

    data_mem_resp dut (
        .clk   (clk),
        .reset (reset),
        .E     (E),
        .RW    (RW),
        .SIZE  (SIZE),
        .SE    (SE),
        .A     (A),
        .DI    (DI),
        .DO    (DO),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] sz, input logic se, input logic [7:0] a);
        logic [7:0]  b0, b1, b2, b3;
        logic [15:0] h;
        b0 = m[a];
        b1 = m[a + 8'd1];
        b2 = m[a + 8'd2];
        b3 = m[a + 8'd3];
        h  = {b0, b1};
        if (sz == 2'b00) return se ? {{24{b0[7]}}, b0} : {24'h0, b0};
        if (sz == 2'b01) return se ? {{16{h[15]}}, h} : {16'h0, h};
        return {b0, b1, b2, b3};
    endfunction

    task automatic issue(input stim_t s);
        exp_t        x;
        int          n;
        logic [7:0]  ai;
        logic [31:0] sh;
        n   = (s.sz == 2'b00) ? 1 : (s.sz == 2'b01) ? 2 : 4;
        x.e = model_err(s.sz, s.a);
        if (x.e) begin
            x.d = 32'h0; x.lat = 1; x.busy = 1;
        end else begin
            x.lat = n + 1; x.busy = n + 1;
            if (s.rw) begin
                x.d = last_do;
                for (int i = 0; i < n; i++) begin
                    ai    = s.a + 8'(i);
                    sh    = s.di >> (8 * (n - 1 - i));
                    m[ai] = sh[7:0];
                end
            end else begin
                x.d = model_read(s.sz, s.se, s.a);
            end
        end
        last_do = x.d;
        sb.push_back(x);
        @(negedge clk);
        E = 1'b1; RW = s.rw; SIZE = s.sz; SE = s.se; A = s.a; DI = s.di;
        @(posedge clk);
        #1 E = 1'b0;
    endtask

    task automatic collect(output logic [31:0] d, output logic er, output int lat, output int busy);
        d = 32'h0; er = 1'b0; lat = -1; busy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (BUSY) busy++;
            if (DONE) begin
                lat = k; d = DO; er = ERR;
                break;
            end
        end
    endtask

    task automatic test_reset();
        E = 1'b0; RW = 1'b0; SIZE = 2'b00; SE = 1'b0; A = 8'h00; DI = 32'h0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (DO !== 32'h0)  $display("FAIL reset_DO got %h exp 00000000", DO);  else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL reset_BUSY got %b exp 0", BUSY);    else passed++;
        total++; if (DONE !== 1'b0) $display("FAIL reset_DONE got %b exp 0", DONE);    else passed++;
        total++; if (ERR !== 1'b0)  $display("FAIL reset_ERR got %b exp 0", ERR);      else passed++;
        reset = 1'b1;
        last_do = 32'h0;
    endtask

    task automatic test_word();
        stim_t t[5] = '{
            '{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF},
            '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0},
            '{1'b0, 2'b00, 1'b0, 8'h10, 32'h0},
            '{1'b0, 2'b00, 1'b0, 8'h11, 32'h0},
            '{1'b0, 2'b00, 1'b0, 8'h12, 32'h0}};
        logic [31:0] od; logic oe; int ol, ob; exp_t x;
        for (int i = 0; i < 5; i++) begin
            issue(t[i]);
            collect(od, oe, ol, ob);
            x = sb.pop_front();
            total++; if (od !== x.d)    $display("FAIL word%0d_DO got %h exp %h", i, od, x.d);      else passed++;
            total++; if (oe !== x.e)    $display("FAIL word%0d_ERR got %b exp %b", i, oe, x.e);     else passed++;
            total++; if (ol != x.lat)   $display("FAIL word%0d_lat got %0d exp %0d", i, ol, x.lat);  else passed++;
            total++; if (ob != x.busy)  $display("FAIL word%0d_busy got %0d exp %0d", i, ob, x.busy); else passed++;
        end
    endtask

    task automatic test_byte_half();
        stim_t t[7] = '{
            '{1'b0, 2'b00, 1'b1, 8'h13, 32'h0},
            '{1'b0, 2'b00, 1'b0, 8'h13, 32'h0},
            '{1'b0, 2'b01, 1'b1, 8'h12, 32'h0},
            '{1'b1, 2'b01, 1'b0, 8'h20, 32'h00001234},
            '{1'b0, 2'b00, 1'b0, 8'h20, 32'h0},
            '{1'b0, 2'b00, 1'b1, 8'h21, 32'h0},
            '{1'b0, 2'b01, 1'b1, 8'h20, 32'h0}};
        logic [31:0] od; logic oe; int ol, ob; exp_t x;
        for (int i = 0; i < 7; i++) begin
            issue(t[i]);
            collect(od, oe, ol, ob);
            x = sb.pop_front();
            total++; if (od !== x.d)    $display("FAIL bh%0d_DO got %h exp %h", i, od, x.d);      else passed++;
            total++; if (oe !== x.e)    $display("FAIL bh%0d_ERR got %b exp %b", i, oe, x.e);     else passed++;
            total++; if (ol != x.lat)   $display("FAIL bh%0d_lat got %0d exp %0d", i, ol, x.lat);  else passed++;
            total++; if (ob != x.busy)  $display("FAIL bh%0d_busy got %0d exp %0d", i, ob, x.busy); else passed++;
        end
    endtask

    task automatic test_errors();
        stim_t t[6] = '{
            '{1'b0, 2'b10, 1'b0, 8'h11, 32'h0},
            '{1'b0, 2'b01, 1'b1, 8'h21, 32'h0},
            '{1'b0, 2'b11, 1'b0, 8'h10, 32'h0},
            '{1'b1, 2'b10, 1'b0, 8'h12, 32'hFFFFFFFF},
            '{1'b0, 2'b10, 1'b0, 8'h10, 32'h0},
            '{1'b0, 2'b01, 1'b0, 8'h20, 32'h0}};
        logic [31:0] od; logic oe; int ol, ob; exp_t x;
        for (int i = 0; i < 6; i++) begin
            issue(t[i]);
            collect(od, oe, ol, ob);
            x = sb.pop_front();
            total++; if (od !== x.d)    $display("FAIL err%0d_DO got %h exp %h", i, od, x.d);      else passed++;
            total++; if (oe !== x.e)    $display("FAIL err%0d_ERR got %b exp %b", i, oe, x.e);     else passed++;
            total++; if (ol != x.lat)   $display("FAIL err%0d_lat got %0d exp %0d", i, ol, x.lat);  else passed++;
            total++; if (ob != x.busy)  $display("FAIL err%0d_busy got %0d exp %0d", i, ob, x.busy); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t x1, x2, x;
        int   ndone, k_idle_busy;
        int   kd[2];
        logic [31:0] dd[2];
        x1.d = model_read(2'b10, 1'b0, 8'h10); x1.e = 1'b0; x1.lat = 5; x1.busy = 5;
        x2.d = model_read(2'b00, 1'b1, 8'h13); x2.e = 1'b0; x2.lat = 8; x2.busy = 2;
        sb.push_back(x1);
        sb.push_back(x2);
        last_do = x2.d;
        ndone = 0; k_idle_busy = -1; kd[0] = -1; kd[1] = -1; dd[0] = 32'h0; dd[1] = 32'h0;
        @(negedge clk);
        E = 1'b1; RW = 1'b0; SIZE = 2'b10; SE = 1'b0; A = 8'h10; DI = 32'h0;
        @(posedge clk);
        #1 SIZE = 2'b00; SE = 1'b1; A = 8'h13;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) k_idle_busy = int'(BUSY);
            if (DONE && ndone < 2) begin
                kd[ndone] = k; dd[ndone] = DO; ndone++;
            end
            if (ndone == 2) break;
        end
        E = 1'b0;
        for (int j = 0; j < 2; j++) begin
            x = sb.pop_front();
            total++; if (kd[j] != x.lat) $display("FAIL b2b%0d_lat got %0d exp %0d", j, kd[j], x.lat); else passed++;
            total++; if (dd[j] !== x.d)  $display("FAIL b2b%0d_DO got %h exp %h", j, dd[j], x.d);      else passed++;
        end
        total++; if (k_idle_busy != 0) $display("FAIL b2b_idle_busy got %0d exp 0", k_idle_busy); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        stim_t pre  = '{1'b1, 2'b10, 1'b0, 8'h40, 32'hAABBCCDD};
        stim_t post = '{1'b0, 2'b10, 1'b0, 8'h40, 32'h0};
        logic [31:0] od; logic oe; int ol, ob; exp_t x;
        issue(pre);
        collect(od, oe, ol, ob);
        x = sb.pop_front();
        total++; if (ol != x.lat) $display("FAIL rst_pre_lat got %0d exp %0d", ol, x.lat); else passed++;
        @(negedge clk);
        E = 1'b1; RW = 1'b1; SIZE = 2'b10; SE = 1'b0; A = 8'h40; DI = 32'h11223344;
        @(posedge clk);
        #1 E = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (DO !== 32'h0)  $display("FAIL rst_mid_DO got %h exp 00000000", DO); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL rst_mid_BUSY got %b exp 0", BUSY);   else passed++;
        total++; if (DONE !== 1'b0) $display("FAIL rst_mid_DONE got %b exp 0", DONE);   else passed++;
        total++; if (ERR !== 1'b0)  $display("FAIL rst_mid_ERR got %b exp 0", ERR);     else passed++;
        m[8'h40] = 8'h11;
        m[8'h41] = 8'h22;
        last_do = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        issue(post);
        collect(od, oe, ol, ob);
        x = sb.pop_front();
        total++; if (od !== x.d)  $display("FAIL rst_post_DO got %h exp %h", od, x.d);      else passed++;
        total++; if (ol != x.lat) $display("FAIL rst_post_lat got %0d exp %0d", ol, x.lat); else passed++;
        total++; if (oe !== x.e)  $display("FAIL rst_post_ERR got %b exp %b", oe, x.e);     else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
